// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Defines the FSM state encoding, the fault cause codes and the counter width.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10,
        FC_INIT     = 2'b11
    } fault_cause_t;

    localparam int CNT_W = 32;

endpackage

// File: rtl/dmem_responder_if.sv
// Datapath-to-data-memory bus.
// The datapath drives the master side and the memory responder implements the slave side.
interface dmem_responder_if #(
    parameter int N = 64
);
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_writeEnable;
    logic         DM_readEnable;
    logic [N-1:0] DM_readData;

    modport master (
        output DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
        input  DM_readData
    );

    modport slave (
        input  DM_addr, DM_writeData, DM_writeEnable, DM_readEnable,
        output DM_readData
    );
endinterface

// File: rtl/dmem_responder_sat_counter.sv
// Event counter that saturates at all-ones instead of wrapping.
// The clear input is synchronous.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-addressed data memory for the single-cycle core: combinational read, synchronous write,
// self-initialization after reset, sticky first-fault capture and saturating access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_responder_if.slave       dm,
    output logic                  ready,
    input  logic                  fault_clear,
    output logic                  fault,
    output logic [N-1:0]          fault_addr,
    output logic [1:0]            fault_cause,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t        state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [N-1:0]       mem [DEPTH];

    logic [IDX_W-1:0]   word_idx;
    logic               access;
    fault_cause_t       cause;
    logic               bad;
    logic               rd_accept;
    logic               wr_accept;

    logic               fault_q;
    logic [N-1:0]       fault_addr_q;
    fault_cause_t       fault_cause_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        case (state_q)
            INIT: begin
                if (idx_q == IDX_W'(DEPTH - 1)) begin
                    state_n = RUN;
                end else begin
                    idx_n = idx_q + 1'b1;
                end
            end
            RUN:     state_n = RUN;
            default: state_n = INIT;
        endcase
    end

    assign ready    = (state_q == RUN);
    assign word_idx = dm.DM_addr[IDX_W+2:3];
    assign access   = dm.DM_writeEnable | dm.DM_readEnable;

    always_comb begin
        cause = FC_NONE;
        if (state_q == INIT) begin
            cause = FC_INIT;
        end else if (dm.DM_addr[2:0] != 3'b000) begin
            cause = FC_MISALIGN;
        end else if (dm.DM_addr[N-1:IDX_W+3] != '0) begin
            cause = FC_RANGE;
        end
    end

    assign bad       = access && (cause != FC_NONE);
    assign rd_accept = dm.DM_readEnable  && !bad;
    assign wr_accept = dm.DM_writeEnable && !bad;

    // NOTE: the RAM array is deliberately not reset; the INIT sequence gives it known contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == INIT) begin
                mem[idx_q] <= {{(N - IDX_W){1'b0}}, idx_q};
            end else if (wr_accept) begin
                mem[word_idx] <= dm.DM_writeData;
            end
        end
    end

    assign dm.DM_readData = rd_accept ? mem[word_idx] : '0;

    // A new fault wins over a simultaneous clear, so clearing never loses a fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            fault_cause_q <= FC_NONE;
        end else if (bad && (!fault_q || fault_clear)) begin
            fault_q       <= 1'b1;
            fault_addr_q  <= dm.DM_addr;
            fault_cause_q <= cause;
        end else if (fault_clear) begin
            fault_q       <= 1'b0;
            fault_addr_q  <= '0;
            fault_cause_q <= FC_NONE;
        end
    end

    assign fault       = fault_q;
    assign fault_addr  = fault_addr_q;
    assign fault_cause = fault_cause_q;

    sat_counter #(.W(CNT_W)) u_rd_count (
        .clk   (clk),
        .clear (reset),
        .inc   (rd_accept),
        .count (rd_count)
    );

    sat_counter #(.W(CNT_W)) u_wr_count (
        .clk   (clk),
        .clear (reset),
        .inc   (wr_accept),
        .count (wr_count)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table for RUN-mode accesses plus
// hand-written sequences for initialization timing, INIT faults, mid-INIT reset and saturation.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        fault_clear;
    logic        ready;
    logic        fault;
    logic [63:0] fault_addr;
    logic [1:0]  fault_cause;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int checks = 0;
    int errors = 0;

    dmem_responder_if #(.N(64)) dm ();

    dmem_responder #(.N(64), .DEPTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .dm          (dm),
        .ready       (ready),
        .fault_clear (fault_clear),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .fault_cause (fault_cause),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic        fclr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_fault;
        logic [63:0] exp_faddr;
        logic [1:0]  exp_cause;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic fclr,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic [63:0] exp_rdata, input logic exp_fault,
                                input logic [63:0] exp_faddr, input logic [1:0] exp_cause,
                                input logic [31:0] exp_rd, input logic [31:0] exp_wr);
        vec_t v;
        v.we = we; v.re = re; v.fclr = fclr; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_faddr = exp_faddr;
        v.exp_cause = exp_cause; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
        return v;
    endfunction

    task automatic idle();
        dm.DM_writeEnable = 1'b0;
        dm.DM_readEnable  = 1'b0;
        dm.DM_addr        = '0;
        dm.DM_writeData   = '0;
        fault_clear       = 1'b0;
    endtask

    // Drives one access cycle from a negedge, checks read data before the edge and status after it.
    task automatic apply(input vec_t v, input string tag);
        dm.DM_writeEnable = v.we;
        dm.DM_readEnable  = v.re;
        dm.DM_addr        = v.addr;
        dm.DM_writeData   = v.wdata;
        fault_clear       = v.fclr;
        #1;
        check({tag, "_rdata"}, dm.DM_readData, v.exp_rdata);
        @(posedge clk);
        @(negedge clk);
        idle();
        check({tag, "_fault"}, {63'd0, fault}, {63'd0, v.exp_fault});
        check({tag, "_faddr"}, fault_addr, v.exp_faddr);
        check({tag, "_cause"}, {62'd0, fault_cause}, {62'd0, v.exp_cause});
        check({tag, "_rdcnt"}, {32'd0, rd_count}, {32'd0, v.exp_rd});
        check({tag, "_wrcnt"}, {32'd0, wr_count}, {32'd0, v.exp_wr});
    endtask

    // One reset edge; returns at the negedge following it with reset low.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts negedge samples with ready low, bounded so a stuck FSM still reaches the summary.
    task automatic count_init(output int low_cycles);
        low_cycles = 0;
        while (!ready && low_cycles < 200) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int low;
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);

        dm.DM_readEnable = 1'b1;
        dm.DM_addr       = 64'h28;
        #1;
        check("rst_rdata", dm.DM_readData, 64'h0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_fault", {63'd0, fault}, 64'd0);
        check("rst_faddr", fault_addr, 64'd0);
        check("rst_cause", {62'd0, fault_cause}, 64'd0);
        check("rst_rdcnt", {32'd0, rd_count}, 64'd0);
        check("rst_wrcnt", {32'd0, wr_count}, 64'd0);
        idle();

        @(negedge clk);
        reset = 1'b0;
        count_init(low);
        check("init_low_cycles", 64'(low), 64'd64);

        vecs.push_back(mk(0, 1, 0, 64'h28,  0,            64'h5,        0, 64'h0,   2'b00, 1, 0));
        vecs.push_back(mk(0, 1, 0, 64'h1F8, 0,            64'h3F,       0, 64'h0,   2'b00, 2, 0));
        vecs.push_back(mk(1, 0, 0, 64'h10,  64'hDEADBEEF, 64'h0,        0, 64'h0,   2'b00, 2, 1));
        vecs.push_back(mk(0, 1, 0, 64'h10,  0,            64'hDEADBEEF, 0, 64'h0,   2'b00, 3, 1));
        vecs.push_back(mk(1, 1, 0, 64'h18,  64'h7,        64'h3,        0, 64'h0,   2'b00, 4, 2));
        vecs.push_back(mk(0, 1, 0, 64'h18,  0,            64'h7,        0, 64'h0,   2'b00, 5, 2));
        vecs.push_back(mk(1, 0, 0, 64'h13,  64'h55,       64'h0,        1, 64'h13,  2'b01, 5, 2));
        vecs.push_back(mk(0, 1, 0, 64'h10,  0,            64'hDEADBEEF, 1, 64'h13,  2'b01, 6, 2));
        vecs.push_back(mk(0, 1, 0, 64'h400, 0,            64'h0,        1, 64'h13,  2'b01, 6, 2));
        vecs.push_back(mk(0, 0, 1, 64'h0,   0,            64'h0,        0, 64'h0,   2'b00, 6, 2));
        vecs.push_back(mk(0, 1, 0, 64'h200, 0,            64'h0,        1, 64'h200, 2'b10, 6, 2));
        vecs.push_back(mk(0, 1, 1, 64'h201, 0,            64'h0,        1, 64'h201, 2'b01, 6, 2));
        vecs.push_back(mk(0, 0, 1, 64'h0,   0,            64'h0,        0, 64'h0,   2'b00, 6, 2));
        vecs.push_back(mk(0, 1, 0, 64'h8000_0000_0000_0000, 0, 64'h0,   1, 64'h8000_0000_0000_0000, 2'b10, 6, 2));
        vecs.push_back(mk(1, 0, 1, 64'h1F8, 64'hA5,       64'h0,        0, 64'h0,   2'b00, 6, 3));
        vecs.push_back(mk(0, 1, 0, 64'h1F8, 0,            64'hA5,       0, 64'h0,   2'b00, 7, 3));
        vecs.push_back(mk(1, 1, 0, 64'h1C,  64'h99,       64'h0,        1, 64'h1C,  2'b01, 7, 3));
        vecs.push_back(mk(0, 1, 0, 64'h18,  0,            64'h7,        1, 64'h1C,  2'b01, 8, 3));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Write during INIT: faults with cause 11 and must not disturb the init pattern.
        pulse_reset();
        repeat (5) @(negedge clk);
        apply(mk(1, 0, 0, 64'h8, 64'hFF, 64'h0, 1, 64'h8, 2'b11, 0, 0), "init_wr");
        count_init(low);
        check("init_wr_ready", {63'd0, ready}, 64'd1);
        apply(mk(0, 1, 0, 64'h8, 0, 64'h1, 1, 64'h8, 2'b11, 1, 0), "init_wr_mem1");

        // Reset again 30 cycles into INIT: the full 64-cycle sequence restarts and status clears.
        pulse_reset();
        repeat (30) @(negedge clk);
        pulse_reset();
        count_init(low);
        check("midinit_low_cycles", 64'(low), 64'd64);
        check("midinit_fault", {63'd0, fault}, 64'd0);
        check("midinit_cause", {62'd0, fault_cause}, 64'd0);
        check("midinit_rdcnt", {32'd0, rd_count}, 64'd0);
        check("midinit_wrcnt", {32'd0, wr_count}, 64'd0);

        force dut.u_wr_count.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_wr_count.count;
        check("sat_preload", {32'd0, wr_count}, 64'hFFFF_FFFE);
        apply(mk(1, 0, 0, 64'h0, 64'h11, 64'h0, 0, 64'h0, 2'b00, 0, 32'hFFFF_FFFF), "sat_wr1");
        apply(mk(1, 0, 0, 64'h0, 64'h22, 64'h0, 0, 64'h0, 2'b00, 0, 32'hFFFF_FFFF), "sat_wr2");
        apply(mk(1, 0, 0, 64'h0, 64'h33, 64'h0, 0, 64'h0, 2'b00, 0, 32'hFFFF_FFFF), "sat_wr3");
        apply(mk(0, 1, 0, 64'h0, 0, 64'h33, 0, 64'h0, 2'b00, 1, 32'hFFFF_FFFF), "sat_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
